// File: rtl/led_strip_driver.sv
// led_strip_driver
//
// Serializes 24-bit per-LED colours onto a single-wire WS2812-style strand.
// Colours are requested by LED index, sampled a fixed number of cycles after
// the request changes, and sent as G,R,B, MSB first. A long low period
// follows each frame so the strand latches the new colours.
//
// Optional build macro:
//   LED_STRIP_BRIGHTNESS_LIMIT_EN - when defined, every captured channel is
//   shifted right by 2 before it is sent, which caps each channel at 8'h3F.
//   When undefined, channels are sent unmodified.
//
// Ports:
//   clk              - system clock
//   rst_n            - asynchronous active-low reset
//   green_in         - green value for the LED on next_led_request
//   red_in           - red value for the LED on next_led_request
//   blue_in          - blue value for the LED on next_led_request
//   color_valid      - colour inputs are meaningful this cycle
//   next_led_request - index of the LED whose colour is wanted
//   strand_out       - serial data line to the strand (registered)
//   frame_done       - one-cycle pulse when a frame's latch period ends

module led_strip_driver #(
    parameter int NUM_LEDS          = 50,
    parameter int LED_ADDRESS_WIDTH = 6,
    parameter int T0H_CYCLES        = 35,
    parameter int T0L_CYCLES        = 80,
    parameter int T1H_CYCLES        = 70,
    parameter int T1L_CYCLES        = 60,
    parameter int LATCH_CYCLES      = 5000,
    parameter int REQ_LATENCY       = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   green_in,
    input  logic [7:0]                   red_in,
    input  logic [7:0]                   blue_in,
    input  logic                         color_valid,
    output logic [LED_ADDRESS_WIDTH-1:0] next_led_request,
    output logic                         strand_out,
    output logic                         frame_done
);

    // One shared down-the-line cycle counter serves every state, so it must
    // hold the largest terminal count any state can reach.
    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = maxOf(maxOf(maxOf(T0H_CYCLES, T0L_CYCLES),
                                         maxOf(T1H_CYCLES, T1L_CYCLES)),
                                   maxOf(LATCH_CYCLES, REQ_LATENCY));
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] LATCH_LAST   = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] T0H_LAST     = CNT_W'(T0H_CYCLES - 1);
    localparam logic [CNT_W-1:0] T0L_LAST     = CNT_W'(T0L_CYCLES - 1);
    localparam logic [CNT_W-1:0] T1H_LAST     = CNT_W'(T1H_CYCLES - 1);
    localparam logic [CNT_W-1:0] T1L_LAST     = CNT_W'(T1L_CYCLES - 1);
    localparam logic [CNT_W-1:0] FETCH_SAMPLE = CNT_W'(REQ_LATENCY - 1);
    localparam logic [CNT_W-1:0] FETCH_GO     = CNT_W'(REQ_LATENCY);

    localparam logic [LED_ADDRESS_WIDTH-1:0] LAST_LED = LED_ADDRESS_WIDTH'(NUM_LEDS - 1);
    localparam logic [LED_ADDRESS_WIDTH-1:0] REQ_ONE  = LED_ADDRESS_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_LATCH    = 2'd0,
        ST_FETCH    = 2'd1,
        ST_BIT_HIGH = 2'd2,
        ST_BIT_LOW  = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [4:0]                     bit_cnt_q, bit_cnt_d;
    logic [23:0]                    shift_q, shift_d;
    logic [LED_ADDRESS_WIDTH-1:0]   req_q, req_d;
    logic                           strand_q, strand_d;
    logic                           frame_done_q, frame_done_d;

    logic [23:0]                    captured;
    logic [CNT_W-1:0]               high_last;
    logic [CNT_W-1:0]               low_last;

    // Colour word as it will be serialized, GRB order.
`ifdef LED_STRIP_BRIGHTNESS_LIMIT_EN
    logic brightness_unused;
    assign brightness_unused = ^{green_in[1:0], red_in[1:0], blue_in[1:0]};
    assign captured = {2'b00, green_in[7:2], 2'b00, red_in[7:2], 2'b00, blue_in[7:2]};
`else
    assign captured = {green_in, red_in, blue_in};
`endif

    // The bit currently on the wire is always the shift register MSB.
    assign high_last = shift_q[23] ? T1H_LAST : T0H_LAST;
    assign low_last  = shift_q[23] ? T1L_LAST : T0L_LAST;

    // Next-state logic. FETCH samples the colour after REQ_LATENCY cycles,
    // then spends one more cycle so that strand_out can be a plain register
    // driven from the next state and still rise exactly when bit timing
    // starts. While color_valid is low the wait counter parks on the sample
    // count and the sample is retried every cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        req_d        = req_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            ST_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d      = ST_FETCH;
                    cnt_d        = '0;
                    req_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_FETCH: begin
                if (cnt_q == FETCH_GO) begin
                    state_d = ST_BIT_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == FETCH_SAMPLE) begin
                    if (color_valid) begin
                        shift_d   = captured;
                        bit_cnt_d = 5'd23;
                        cnt_d     = FETCH_GO;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_BIT_HIGH: begin
                if (cnt_q == high_last) begin
                    state_d = ST_BIT_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_BIT_LOW: begin
                if (cnt_q == low_last) begin
                    cnt_d = '0;
                    if (bit_cnt_q == 5'd0) begin
                        if (req_q == LAST_LED) begin
                            state_d = ST_LATCH;
                        end else begin
                            req_d   = req_q + REQ_ONE;
                            state_d = ST_FETCH;
                        end
                    end else begin
                        shift_d   = {shift_q[22:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - 5'd1;
                        state_d   = ST_BIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_LATCH;
                cnt_d   = '0;
            end
        endcase

        // Registered from the next state so the line changes on the same
        // edge as the state and never glitches.
        strand_d = (state_d == ST_BIT_HIGH);
    end

    // State and output registers; reset drops the line low immediately and
    // restarts with a full latch period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LATCH;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            req_q        <= '0;
            strand_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            req_q        <= req_d;
            strand_q     <= strand_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign next_led_request = req_q;
    assign strand_out       = strand_q;
    assign frame_done       = frame_done_q;

endmodule

// File: tb/tb_led_strip_driver.sv
// tb_led_strip_driver
//
// Drives led_strip_driver with a small strand (3 LEDs, short bit times) and
// an upstream colour source that registers its colour one cycle after the
// request. Expected colour words go into a queue when colours are set up; a
// line monitor decodes strand_out back into words for the tasks to compare.

module tb_led_strip_driver;

    localparam int NUM_LEDS  = 3;
    localparam int ADDR_W    = 2;
    localparam int T0H       = 2;
    localparam int T0L       = 4;
    localparam int T1H       = 4;
    localparam int T1L       = 2;
    localparam int LATCH     = 10;
    localparam int REQ_LAT   = 2;
    localparam int FRAME_CYC = LATCH + NUM_LEDS * (REQ_LAT + 1 + 24 * 6);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        greenIn = '0;
    logic [7:0]        redIn = '0;
    logic [7:0]        blueIn = '0;
    logic              colorValid = 1'b1;
    logic [ADDR_W-1:0] nextLedRequest;
    logic              strandOut;
    logic              frameDone;

    logic [7:0]        ledG [0:3];
    logic [7:0]        ledR [0:3];
    logic [7:0]        ledB [0:3];

    logic [23:0]       expQ[$];
    logic [23:0]       rxQ[$];
    int                reqSeq[$];

    int                testsRun = 0;
    int                testsFailed = 0;
    int                timingErrs = 0;
    int                cycleCnt = 0;
    int                frameDoneCycle = 0;

    led_strip_driver #(
        .NUM_LEDS(NUM_LEDS), .LED_ADDRESS_WIDTH(ADDR_W),
        .T0H_CYCLES(T0H), .T0L_CYCLES(T0L), .T1H_CYCLES(T1H), .T1L_CYCLES(T1L),
        .LATCH_CYCLES(LATCH), .REQ_LATENCY(REQ_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .green_in(greenIn), .red_in(redIn), .blue_in(blueIn),
        .color_valid(colorValid),
        .next_led_request(nextLedRequest),
        .strand_out(strandOut),
        .frame_done(frameDone)
    );

    always #5 clk = ~clk;

    // Upstream colour source: one register stage behind the request.
    initial begin
        forever begin
            @(posedge clk);
            greenIn <= ledG[nextLedRequest];
            redIn   <= ledR[nextLedRequest];
            blueIn  <= ledB[nextLedRequest];
            cycleCnt <= cycleCnt + 1;
        end
    end

    // Line monitor: turns high/low run lengths into bits and 24-bit words,
    // and counts any pulse whose width matches neither bit encoding.
    initial begin
        int hiLen = 0, loLen = 0, lastHi = 0, bitIdx = 0;
        logic prevLvl = 1'b0;
        logic [23:0] word = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hiLen = 0; loLen = 0; bitIdx = 0; word = '0; prevLvl = 1'b0;
            end else begin
                if (strandOut) begin
                    if (!prevLvl) begin
                        if (bitIdx != 0 && loLen != ((lastHi == T1H) ? T1L : T0L))
                            timingErrs++;
                        hiLen = 0;
                    end
                    hiLen++;
                end else begin
                    if (prevLvl) begin
                        if (hiLen != T1H && hiLen != T0H) timingErrs++;
                        word = {word[22:0], (hiLen == T1H)};
                        lastHi = hiLen;
                        bitIdx++;
                        loLen = 0;
                        if (bitIdx == 24) begin
                            rxQ.push_back(word);
                            bitIdx = 0;
                        end
                    end
                    loLen++;
                end
                prevLvl = strandOut;
            end
        end
    end

    // Request tracker: records every change of next_led_request.
    initial begin
        int lastReq = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lastReq = 0;
            end else if (int'(nextLedRequest) != lastReq) begin
                lastReq = int'(nextLedRequest);
                reqSeq.push_back(lastReq);
            end
        end
    end

    // Expected serialized word for a colour, GRB order.
    function automatic logic [23:0] expWord(input logic [7:0] g, input logic [7:0] r,
                                            input logic [7:0] b);
`ifdef LED_STRIP_BRIGHTNESS_LIMIT_EN
        return {g >> 2, r >> 2, b >> 2};
`else
        return {g, r, b};
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Loads one LED colour into the upstream source and queues its word.
    task automatic applyStimulus(input int idx, input logic [7:0] g,
                                 input logic [7:0] r, input logic [7:0] b);
        ledG[idx] = g; ledR[idx] = r; ledB[idx] = b;
        expQ.push_back(expWord(g, r, b));
    endtask

    // Reset state, then the first latch period and FETCH gap after release.
    task automatic test_reset();
        int fdCount = 0, fdAt = -1;
        bit lowOk = 1'b1;
        applyStimulus(0, 8'h80, 8'h00, 8'h01);
        applyStimulus(1, 8'hA5, 8'h3C, 8'h0F);
        applyStimulus(2, 8'hFF, 8'h00, 8'hAA);
        ledG[3] = '0; ledR[3] = '0; ledB[3] = '0;
        rst_n = 1'b0;
        colorValid = 1'b1;
        repeat (3) @(negedge clk);
        testsRun++;
        if (strandOut !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL reset_strand: got %b, expected 0", strandOut);
        end
        testsRun++;
        if (nextLedRequest !== 2'd0) begin
            testsFailed++; $display("[TB] FAIL reset_request: got %0d, expected 0", nextLedRequest);
        end
        testsRun++;
        if (frameDone !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL reset_frame_done: got %b, expected 0", frameDone);
        end
        reqSeq.delete();
        rst_n = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (frameDone === 1'b1) begin
                fdCount++; fdAt = k; frameDoneCycle = cycleCnt;
            end
            if (k <= 12 && strandOut !== 1'b0) lowOk = 1'b0;
            if (k == 10) begin
                testsRun++;
                if (nextLedRequest !== 2'd0) begin
                    testsFailed++; $display("[TB] FAIL latch_end_request: got %0d, expected 0", nextLedRequest);
                end
            end
        end
        testsRun++;
        if (fdCount !== 1 || fdAt !== 10) begin
            testsFailed++;
            $display("[TB] FAIL first_frame_done: got %0d pulses at cycle %0d, expected 1 at cycle 10", fdCount, fdAt);
        end
        testsRun++;
        if (lowOk !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL latch_and_gap_low: got a high sample, expected low for 12 cycles");
        end
        testsRun++;
        if (strandOut !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL first_rise: got %b at cycle 13, expected 1", strandOut);
        end
    endtask

    // Cycle-by-cycle waveform of LED 0, then the inter-LED gap.
    task automatic test_bit_pattern();
        logic [23:0] w;
        int errs = 0, firstBad = -1, i = 0;
        bit first = 1'b1, gapOk = 1'b1;
        w = expWord(8'h80, 8'h00, 8'h01);
        for (int b = 23; b >= 0; b--) begin
            int hi, per;
            hi  = w[b] ? T1H : T0H;
            per = w[b] ? (T1H + T1L) : (T0H + T0L);
            for (int c = 0; c < per; c++) begin
                if (!first) tick();
                first = 1'b0;
                if (strandOut !== (c < hi)) begin
                    errs++;
                    if (firstBad < 0) firstBad = i;
                end
                i++;
            end
        end
        testsRun++;
        if (errs !== 0) begin
            testsFailed++;
            $display("[TB] FAIL led0_waveform: got %0d wrong cycles (first at %0d), expected 0", errs, firstBad);
        end
        for (int g = 1; g <= REQ_LAT + 1; g++) begin
            tick();
            if (strandOut !== 1'b0) gapOk = 1'b0;
            if (g == 1) begin
                testsRun++;
                if (nextLedRequest !== 2'd1) begin
                    testsFailed++; $display("[TB] FAIL request_step: got %0d, expected 1", nextLedRequest);
                end
            end
        end
        testsRun++;
        if (gapOk !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL led_gap_low: got a high sample, expected %0d low cycles", REQ_LAT + 1);
        end
        tick();
        testsRun++;
        if (strandOut !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL led1_rise: got %b, expected 1", strandOut);
        end
        testsRun++;
        if (rxQ.size() == 0 || expQ.size() == 0) begin
            testsFailed++; $display("[TB] FAIL led0_word: got no word, expected %06h", w);
        end else begin
            logic [23:0] got, exp;
            got = rxQ.pop_front(); exp = expQ.pop_front();
            if (got !== exp) begin
                testsFailed++; $display("[TB] FAIL led0_word: got %06h, expected %06h", got, exp);
            end
        end
    endtask

    // Remaining words of a frame, frame period and request sequence.
    task automatic test_full_frame(input int nWords);
        int guard = 0;
        for (int n = 0; n < nWords; n++) begin
            guard = 0;
            while (rxQ.size() == 0 && guard < FRAME_CYC) begin tick(); guard++; end
            testsRun++;
            if (rxQ.size() == 0 || expQ.size() == 0) begin
                testsFailed++; $display("[TB] FAIL frame_word_%0d: got nothing within %0d cycles", n, FRAME_CYC);
            end else begin
                logic [23:0] got, exp;
                got = rxQ.pop_front(); exp = expQ.pop_front();
                if (got !== exp) begin
                    testsFailed++; $display("[TB] FAIL frame_word_%0d: got %06h, expected %06h", n, got, exp);
                end
            end
        end
        guard = 0;
        while (frameDone !== 1'b1 && guard < 2 * FRAME_CYC) begin tick(); guard++; end
        #1;
        testsRun++;
        if (frameDone !== 1'b1 || cycleCnt - frameDoneCycle !== FRAME_CYC) begin
            testsFailed++;
            $display("[TB] FAIL frame_interval: got %0d cycles (pulse %b), expected %0d", cycleCnt - frameDoneCycle, frameDone, FRAME_CYC);
        end
        frameDoneCycle = cycleCnt;
        testsRun++;
        if (reqSeq.size() != 3 || reqSeq[0] != 1 || reqSeq[1] != 2 || reqSeq[2] != 0) begin
            testsFailed++;
            $display("[TB] FAIL request_sequence: got %0d changes %p, expected 1,2,0 after 0", reqSeq.size(), reqSeq);
        end
        reqSeq.delete();
        testsRun++;
        if (timingErrs !== 0) begin
            testsFailed++; $display("[TB] FAIL bit_timing: got %0d bad pulses, expected 0", timingErrs);
        end
    endtask

    // color_valid held low through the FETCH of LED 1.
    task automatic test_stall();
        int guard = 0;
        bit holdOk = 1'b1;
        applyStimulus(0, 8'h80, 8'h00, 8'h01);
        applyStimulus(1, 8'h00, 8'hFF, 8'h81);
        applyStimulus(2, 8'h12, 8'h34, 8'h56);
        while (nextLedRequest !== 2'd1 && guard < FRAME_CYC) begin tick(); guard++; end
        colorValid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (strandOut !== 1'b0 || nextLedRequest !== 2'd1) holdOk = 1'b0;
        end
        testsRun++;
        if (holdOk !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL stall_hold: got strand %b req %0d, expected 0 and 1", strandOut, nextLedRequest);
        end
        colorValid = 1'b1;
        tick();
        testsRun++;
        if (strandOut !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL stall_sample_cycle: got %b, expected 0", strandOut);
        end
        tick();
        testsRun++;
        if (strandOut !== 1'b1) begin
            testsFailed++; $display("[TB] FAIL stall_resume: got %b, expected 1", strandOut);
        end
    endtask

    // Reset asserted while LED 2 is in a high phase.
    task automatic test_reset_mid();
        int guard = 0, fdAt = -1;
        bit lowOk = 1'b1;
        for (int n = 0; n < 2; n++) begin
            guard = 0;
            while (rxQ.size() == 0 && guard < FRAME_CYC) begin tick(); guard++; end
            testsRun++;
            if (rxQ.size() == 0 || expQ.size() == 0) begin
                testsFailed++; $display("[TB] FAIL stall_frame_word_%0d: got nothing", n);
            end else begin
                logic [23:0] got, exp;
                got = rxQ.pop_front(); exp = expQ.pop_front();
                if (got !== exp) begin
                    testsFailed++; $display("[TB] FAIL stall_frame_word_%0d: got %06h, expected %06h", n, got, exp);
                end
            end
        end
        guard = 0;
        while (!(nextLedRequest === 2'd2 && strandOut === 1'b1) && guard < FRAME_CYC) begin tick(); guard++; end
        #2 rst_n = 1'b0;
        #1;
        testsRun++;
        if (strandOut !== 1'b0 || guard >= FRAME_CYC) begin
            testsFailed++; $display("[TB] FAIL async_drop: got %b (wait %0d), expected 0", strandOut, guard);
        end
        testsRun++;
        if (nextLedRequest !== 2'd0 || frameDone !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL async_outputs: got req %0d done %b, expected 0 and 0", nextLedRequest, frameDone);
        end
        void'(expQ.pop_front());
        applyStimulus(0, 8'hFF, 8'hFF, 8'hFF);
        applyStimulus(1, 8'h01, 8'h02, 8'h03);
        applyStimulus(2, 8'h55, 8'hAA, 8'hC3);
        repeat (2) @(negedge clk);
        testsRun++;
        if (rxQ.size() !== 0) begin
            testsFailed++; $display("[TB] FAIL partial_word: got %0d words, expected 0", rxQ.size());
        end
        reqSeq.delete();
        rst_n = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (frameDone === 1'b1 && fdAt < 0) begin fdAt = k; frameDoneCycle = cycleCnt; end
            if (k <= 12 && (strandOut !== 1'b0 || nextLedRequest !== 2'd0)) lowOk = 1'b0;
        end
        testsRun++;
        if (fdAt !== LATCH || lowOk !== 1'b1 || strandOut !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL restart_latch: got pulse at %0d low %b rise %b, expected 10, 1, 1", fdAt, lowOk, strandOut);
        end
    endtask

    // All-ones colour: limited build sends 3F per channel.
    task automatic test_brightness();
        int guard = 0;
        while (rxQ.size() == 0 && guard < FRAME_CYC) begin tick(); guard++; end
        testsRun++;
        if (rxQ.size() == 0 || expQ.size() == 0) begin
            testsFailed++; $display("[TB] FAIL brightness_word: got nothing");
        end else begin
            logic [23:0] got, exp;
            got = rxQ.pop_front(); exp = expQ.pop_front();
            if (got !== exp) begin
                testsFailed++; $display("[TB] FAIL brightness_word: got %06h, expected %06h", got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bit_pattern();
        test_full_frame(2);
        test_stall();
        test_reset_mid();
        test_brightness();
        test_full_frame(2);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
